// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, flag and memory-port controller for the async FIFO
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_nrst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   g_rptr,
  input  logic                  clr_overflow,
  output logic [ADDR_WIDTH:0]   g_wrptr,
  output logic [ADDR_WIDTH:0]   b_wrptr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full when the write pointer equals the read pointer with its two Gray MSBs inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3 << (ADDR_WIDTH - 1));
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic          accept;
  logic [PW-1:0] b_next;
  logic [PW-1:0] g_next;
  logic [PW-1:0] g_rsync;
  logic [PW-1:0] b_rsync;
  logic [PW-1:0] level_next;
  logic [PW-1:0] sync_q [SYNC_STAGES];

  assign accept     = wr_en & ~full & wr_nrst;
  assign mem_wr_en  = accept;
  assign mem_waddr  = b_wrptr[ADDR_WIDTH-1:0];
  assign b_next     = b_wrptr + PW'(accept);
  assign g_next     = b_next ^ (b_next >> 1);
  assign g_rsync    = sync_q[SYNC_STAGES-1];
  assign level_next = b_next - b_rsync;

  always_comb begin
    b_rsync = '0;
    for (int i = 0; i < PW; i++) begin
      b_rsync[i] = ^(g_rsync >> i);
    end
  end

  // Plain flop chain: the Gray pointer changes one bit at a time, so no logic between stages.
  always_ff @(posedge wr_clk or negedge wr_nrst) begin
    if (!wr_nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= g_rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge wr_clk or negedge wr_nrst) begin
    if (!wr_nrst) begin
      b_wrptr     <= '0;
      g_wrptr     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wrptr     <= b_next;
      g_wrptr     <= g_next;
      full        <= (g_next == (g_rsync ^ FULL_MASK));
      almost_full <= (level_next >= AFULL_LVL);
      wr_level    <= level_next;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
